// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_arb_pkg : shared types and constants for the mux4 round-robin arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  // Last-winner pointer after reset, so the first search starts at index 0.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick  : combinational round-robin search, order ptr+1, ptr+2, ptr+3, ptr
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] idx;

  always_comb begin
    cand   = req & ~mask;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux4_rr_arbiter : round-robin sequencer for a shared 4:1 1-bit mux
//                   optional hold-time preemption via MUX_ARB_HOLD_LIMIT_EN
// Revision        : 1.0
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_cfg_check
    $error("mux4_rr_arbiter: HOLD_MAX / CNT_W combination out of range");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] winner;
  logic             found;
  logic             owner_req;
  logic             preempt;

  // Masking with the current grant excludes the owner from the search; in
  // IDLE the grant is zero so every requester competes.
  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .mask   (gnt_q),
    .winner (winner),
    .found  (found)
  );

  assign owner_req = req[sel_q];

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign preempt = (cnt_q == CNT_MAX) && found;

  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT && owner_req && !preempt) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = onehot(winner);
          sel_d   = winner;
          ptr_d   = winner;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || preempt) begin
          if (found) begin
            gnt_d = onehot(winner);
            sel_d = winner;
            ptr_d = winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= PTR_RST;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign y    = busy_q ? din[sel_q] : 1'b0;

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-to-1, 1-bit multiplexer resource.
- Four requesters, each owning one data bit `din[i]`, compete for the single output `y`.
- The block grants one requester at a time and drives the 2-bit mux select.
- It holds the grant until the owner releases, optionally with a hold-time limit, then rotates fairly.

Parameters:
- HOLD_MAX, 8: maximum consecutive grant cycles before forced rotation. Used only with MUX_ARB_HOLD_LIMIT_EN. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  request per requester; level-sensitive; held high while the resource is wanted.
- din  input  4  data bit per requester; `din[i]` belongs to requester i.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  mux select, registered; index of the current/last owner.
- busy  output  1  registered; high while any grant is active (equals OR of gnt).
- y  output  1  combinational; `din[sel]` when busy, else 0.

Behaviour:
- Reset: synchronous. Any rising edge with rst_n=0 forces:
  - state=IDLE, gnt=4'b0000, sel=2'd0, busy=0
  - ptr=2'd3, so the first search starts at index 0
  - hold counter=0
  - Reset mid-grant drops the grant on that edge, with no completion cycle.
- ptr holds the last winner. The search order is ptr+1, ptr+2, ptr+3, ptr (mod 4, 2-bit wrap). The winner is the first index in that order whose req is high.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0: next edge enters GRANT, gnt=onehot(winner), sel=winner, ptr=winner, busy=1, counter=0.
  - Latency from req rising to gnt is 1 cycle.
  - If req == 0: stay in IDLE; sel holds its last value.
- GRANT, owner keeps `req[sel]` high: stay; gnt, sel and ptr are unchanged; counter increments, saturating at HOLD_MAX-1.
- GRANT, owner drops `req[sel]`:
  - Other requests pending: the next edge grants the next winner, searched from ptr+1 excluding the releasing index. There is no idle bubble; busy stays 1; counter=0.
  - No other requests: next edge returns to IDLE, gnt=0, busy=0, sel holds.
- Simultaneous events:
  - Multiple new requests in IDLE: the round-robin order decides.
  - Owner release and new request in the same cycle: treated as release with pending.
  - A requester re-asserting immediately after release is served only after the others in order.
- `y` updates in the same cycle as sel/busy change. There is no extra latency through the mux.
- gnt is always one-hot or zero. sel always equals the encoded gnt when busy=1.

Optional Feature:
- Macro: MUX_ARB_HOLD_LIMIT_EN.
- Defined:
  - When the counter equals HOLD_MAX-1 while the owner still requests and another req is pending, the next edge preempts.
  - Preemption rotates the grant to the next winner, counter=0.
  - The preempted requester re-enters arbitration normally.
  - If no other req is pending, the grant continues and the counter saturates.
- Undefined: the counter logic is not compiled; the grant is held for as long as the owner requests.

Decomposition:
- Shared package `mux_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT}
  - constants N_REQ=4 and SEL_W=2
  - reset constant PTR_RST=2'd3
- Natural sub-module: `rr_pick`, a combinational unit. Inputs req[3:0], ptr[1:0], mask[3:0]. Outputs winner[1:0] and found.
- The top instantiates `rr_pick` once and keeps the FSM, ptr and counter.

Test Plan:
- Reset then single request: rst_n low 2 cycles, req=4'b0100, din=4'b0100 -> one cycle later gnt=4'b0100, sel=2, busy=1, y=1; gnt=0 and sel=0 during reset.
- All-request fairness: req=4'b1111, each owner releases after 1 grant cycle -> grant order 0,1,2,3,0 with no idle cycles between grants.
- Release to idle: owner 1 drops req with no other requests -> next edge gnt=0, busy=0, y=0, sel stays 1; a new req=4'b0001 then grants index 0 (ptr=1, search 2,3,0).
- Reset mid-grant: during GRANT of index 3, rst_n=0 for 1 cycle -> gnt=0 on that edge; after reset, req=4'b1001 grants index 0 first.
- Hold limit (macro defined, HOLD_MAX=4): req=4'b0011 constant -> index 0 granted 4 cycles, then index 1 for 4 cycles, alternating. With only req=4'b0001, the grant persists beyond 4 cycles.
- Macro undefined: same req=4'b0011 constant -> index 0 held indefinitely (check 50 cycles); y tracks `din[0]` toggling every cycle.
